// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the unstallable ALU result stream with the
// handshaked load stream onto the single registered register-file write port.
module wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_exe_valid_i,
    input  logic [4:0]      alu_exe_rd_i,
    input  logic [XLEN-1:0] alu_exe_rd_value_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [4:0]      lsu_rd_i,
    input  logic [XLEN-1:0] lsu_rd_value_i,
    input  logic            flush_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            stall_req_o,
    output logic [63:0]     wb_count_o
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = $clog2(LQ_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(LQ_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX    = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0] STV_THRESH = STV_W'(STARVE_LIMIT - 1);

    logic [4:0]      r_lqRd   [LQ_DEPTH];
    logic [XLEN-1:0] r_lqData [LQ_DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;
    logic [STV_W-1:0] r_starve;
    logic             r_rfWe;
    logic [4:0]       r_rfWaddr;
    logic [XLEN-1:0]  r_rfWdata;
    logic             r_stall;
    logic [63:0]      r_wbCount;

    logic             w_empty;
    logic             w_full;
    logic             w_accept;
    logic             w_aluWin;
    logic             w_bufWin;
    logic             w_bypWin;
    logic             w_pop;
    logic             w_push;
    logic             w_winValid;
    logic [4:0]       w_winRd;
    logic [XLEN-1:0]  w_winData;
    logic             w_we;
    logic             w_stallNext;
    logic [STV_W-1:0] w_starveNext;

    // Ready deliberately ignores a same-cycle pop: a full buffer never reuses the slot.
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign lsu_ready_o = ~rst & ~w_full & ~flush_i;
    assign w_accept    = lsu_valid_i & lsu_ready_o;

    assign w_aluWin = alu_exe_valid_i;
    assign w_bufWin = ~alu_exe_valid_i & ~w_empty & ~flush_i;
    assign w_bypWin = ~alu_exe_valid_i & w_empty & w_accept;
    assign w_pop    = w_bufWin;
    assign w_push   = w_accept & ~w_bypWin;

    always_comb begin
        w_winValid = 1'b0;
        w_winRd    = '0;
        w_winData  = '0;
        if (w_aluWin) begin
            w_winValid = 1'b1;
            w_winRd    = alu_exe_rd_i;
            w_winData  = alu_exe_rd_value_i;
        end else if (w_bufWin) begin
            w_winValid = 1'b1;
            w_winRd    = r_lqRd[r_rdPtr];
            w_winData  = r_lqData[r_rdPtr];
        end else if (w_bypWin) begin
            w_winValid = 1'b1;
            w_winRd    = lsu_rd_i;
            w_winData  = lsu_rd_value_i;
        end
    end

    // A winner targeting x0 is consumed without an architectural write.
    assign w_we = w_winValid & (w_winRd != 5'd0);

    always_comb begin
        w_starveNext = r_starve;
        if (flush_i | w_pop | w_empty) begin
            w_starveNext = '0;
        end else if (w_aluWin && (r_starve != STV_MAX)) begin
            w_starveNext = r_starve + STV_W'(1);
        end
    end

    assign w_stallNext = ((r_starve >= STV_THRESH) & w_aluWin & ~w_empty) | w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_lqRd[r_wrPtr]   <= lsu_rd_i;
            r_lqData[r_wrPtr] <= lsu_rd_value_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_rfWe    <= 1'b0;
            r_rfWaddr <= '0;
            r_rfWdata <= '0;
            r_stall   <= 1'b0;
            r_wbCount <= '0;
        end else begin
            if (flush_i) begin
                r_rdPtr <= '0;
                r_wrPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_W'(1);
                end
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
            r_starve <= w_starveNext;
            r_stall  <= w_stallNext;
            r_rfWe   <= w_we;
            if (w_we) begin
                r_rfWaddr <= w_winRd;
                r_rfWdata <= w_winData;
            end
            r_wbCount <= r_wbCount + 64'(w_we);
        end
    end

    assign rf_we_o     = r_rfWe;
    assign rf_waddr_o  = r_rfWaddr;
    assign rf_wdata_o  = r_rfWdata;
    assign stall_req_o = r_stall;
    assign wb_count_o  = r_wbCount;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand-written multi-cycle
// sequences, then random traffic against a queue-based reference model.
module tb_wb_arbiter;

    localparam int XLEN         = 64;
    localparam int LQ_DEPTH     = 2;
    localparam int STARVE_LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_exe_valid_i;
    logic [4:0]      alu_exe_rd_i;
    logic [XLEN-1:0] alu_exe_rd_value_i;
    logic            lsu_valid_i;
    logic            lsu_ready_o;
    logic [4:0]      lsu_rd_i;
    logic [XLEN-1:0] lsu_rd_value_i;
    logic            flush_i;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;
    logic            stall_req_o;
    logic [63:0]     wb_count_o;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .XLEN(XLEN),
        .LQ_DEPTH(LQ_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alu_exe_valid_i(alu_exe_valid_i),
        .alu_exe_rd_i(alu_exe_rd_i),
        .alu_exe_rd_value_i(alu_exe_rd_value_i),
        .lsu_valid_i(lsu_valid_i),
        .lsu_ready_o(lsu_ready_o),
        .lsu_rd_i(lsu_rd_i),
        .lsu_rd_value_i(lsu_rd_value_i),
        .flush_i(flush_i),
        .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o),
        .stall_req_o(stall_req_o),
        .wb_count_o(wb_count_o)
    );

    typedef struct {
        logic        aluV;
        logic [4:0]  aluRd;
        logic [63:0] aluVal;
        logic        lsuV;
        logic [4:0]  lsuRd;
        logic [63:0] lsuVal;
        logic        flush;
        logic        expReady;
        logic        expWe;
        logic [4:0]  expAddr;
        logic [63:0] expData;
        logic        expStall;
        logic [63:0] expCount;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(int aV, int aRd, longint aVal, int lV, int lRd, longint lVal,
                                   int fl, int eRdy, int eWe, int eAddr, longint eData,
                                   int eStall, longint eCount);
        vec_t v;
        v.aluV     = (aV != 0);
        v.aluRd    = 5'(aRd);
        v.aluVal   = 64'(aVal);
        v.lsuV     = (lV != 0);
        v.lsuRd    = 5'(lRd);
        v.lsuVal   = 64'(lVal);
        v.flush    = (fl != 0);
        v.expReady = (eRdy != 0);
        v.expWe    = (eWe != 0);
        v.expAddr  = 5'(eAddr);
        v.expData  = 64'(eData);
        v.expStall = (eStall != 0);
        v.expCount = 64'(eCount);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic aV, input logic [4:0] aRd, input logic [63:0] aVal,
                                 input logic lV, input logic [4:0] lRd, input logic [63:0] lVal,
                                 input logic fl);
        rst                = r;
        alu_exe_valid_i    = aV;
        alu_exe_rd_i       = aRd;
        alu_exe_rd_value_i = aVal;
        lsu_valid_i        = lV;
        lsu_rd_i           = lRd;
        lsu_rd_value_i     = lVal;
        flush_i            = fl;
    endtask

    // Called just after a falling edge: checks ready mid-cycle, registered outputs after the rise.
    task automatic stepCheck(input string tag, input logic eRdy, input logic eWe, input logic [4:0] eAddr,
                             input logic [63:0] eData, input logic eStall, input logic [63:0] eCount);
        #1;
        checkOutput({tag, " ready"}, 64'(lsu_ready_o), 64'(eRdy));
        @(posedge clk);
        #1;
        checkOutput({tag, " we"}, 64'(rf_we_o), 64'(eWe));
        checkOutput({tag, " waddr"}, 64'(rf_waddr_o), 64'(eAddr));
        checkOutput({tag, " wdata"}, rf_wdata_o, eData);
        checkOutput({tag, " stall"}, 64'(stall_req_o), 64'(eStall));
        checkOutput({tag, " count"}, wb_count_o, eCount);
        @(negedge clk);
    endtask

    // Reference model: the load buffer is just a queue, starvation an unbounded integer.
    logic [4:0]  mqRd[$];
    logic [63:0] mqData[$];
    int          mStarve;
    logic        mWe;
    logic [4:0]  mAddr;
    logic [63:0] mData;
    logic        mStall;
    logic [63:0] mCount;

    function automatic logic modelReady();
        return !rst && (mqRd.size() < LQ_DEPTH) && !flush_i;
    endfunction

    task automatic modelStep();
        int          size0;
        logic        acc;
        logic        win;
        logic        popped;
        logic [4:0]  wr;
        logic [63:0] wd;
        if (rst) begin
            mqRd.delete();
            mqData.delete();
            mStarve = 0;
            mWe     = 1'b0;
            mAddr   = '0;
            mData   = '0;
            mStall  = 1'b0;
            mCount  = '0;
            return;
        end
        size0  = mqRd.size();
        acc    = lsu_valid_i && modelReady();
        win    = 1'b0;
        popped = 1'b0;
        wr     = '0;
        wd     = '0;
        mStall = ((mStarve >= STARVE_LIMIT - 1) && alu_exe_valid_i && size0 > 0) || (size0 == LQ_DEPTH);
        if (alu_exe_valid_i) begin
            win = 1'b1;
            wr  = alu_exe_rd_i;
            wd  = alu_exe_rd_value_i;
        end else if (!flush_i && size0 > 0) begin
            win    = 1'b1;
            popped = 1'b1;
            wr     = mqRd.pop_front();
            wd     = mqData.pop_front();
        end else if (acc) begin
            win = 1'b1;
            acc = 1'b0;
            wr  = lsu_rd_i;
            wd  = lsu_rd_value_i;
        end
        if (flush_i || popped || size0 == 0) begin
            mStarve = 0;
        end else if (alu_exe_valid_i) begin
            mStarve++;
        end
        if (flush_i) begin
            mqRd.delete();
            mqData.delete();
        end
        if (acc) begin
            mqRd.push_back(lsu_rd_i);
            mqData.push_back(lsu_rd_value_i);
        end
        if (win && wr != 5'd0) begin
            mWe    = 1'b1;
            mAddr  = wr;
            mData  = wd;
            mCount = mCount + 64'd1;
        end else begin
            mWe = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // aluV aluRd aluVal  lsuV lsuRd lsuVal flush | rdy we addr data stall count
        vecs.push_back(mkVec(1, 5, 'h1234, 0, 0, 0, 0,      1, 1, 5, 'h1234, 0, 1));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,           1, 0, 5, 'h1234, 0, 1));
        vecs.push_back(mkVec(1, 3, 'hAAA, 1, 7, 'h777, 0,   1, 1, 3, 'hAAA, 0, 2));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,           1, 1, 7, 'h777, 0, 3));
        vecs.push_back(mkVec(1, 1, 'h11, 1, 10, 'hA0, 0,    1, 1, 1, 'h11, 0, 4));
        vecs.push_back(mkVec(1, 2, 'h22, 1, 11, 'hB0, 0,    1, 1, 2, 'h22, 0, 5));
        vecs.push_back(mkVec(1, 4, 'h44, 1, 12, 'hC0, 0,    0, 1, 4, 'h44, 1, 6));
        vecs.push_back(mkVec(0, 0, 0, 1, 12, 'hC0, 0,       0, 1, 10, 'hA0, 1, 7));
        vecs.push_back(mkVec(0, 0, 0, 1, 12, 'hC0, 0,       1, 1, 11, 'hB0, 0, 8));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,           1, 1, 12, 'hC0, 0, 9));
        vecs.push_back(mkVec(1, 0, 'h99, 0, 0, 0, 0,        1, 0, 12, 'hC0, 0, 9));
        vecs.push_back(mkVec(1, 13, 'hD, 1, 14, 'hE, 0,     1, 1, 13, 'hD, 0, 10));
        vecs.push_back(mkVec(1, 15, 'hF, 1, 16, 'h10, 0,    1, 1, 15, 'hF, 0, 11));
        vecs.push_back(mkVec(1, 9, 'h9, 1, 17, 'h17, 1,     0, 1, 9, 'h9, 1, 12));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,           1, 0, 9, 'h9, 0, 12));
        vecs.push_back(mkVec(0, 0, 0, 1, 20, 'h2020, 0,     1, 1, 20, 'h2020, 0, 13));

        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        stepCheck("reset0", 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        stepCheck("reset1", 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);

        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].aluV, vecs[i].aluRd, vecs[i].aluVal,
                          vecs[i].lsuV, vecs[i].lsuRd, vecs[i].lsuVal, vecs[i].flush);
            stepCheck($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expWe, vecs[i].expAddr,
                      vecs[i].expData, vecs[i].expStall, vecs[i].expCount);
        end

        // Starvation: one buffered load loses to the ALU on four consecutive cycles.
        applyStimulus(1'b0, 1'b1, 5'd1, 64'h101, 1'b1, 5'd21, 64'h21, 1'b0);
        stepCheck("starveA", 1'b1, 1'b1, 5'd1, 64'h101, 1'b0, 64'd14);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 5'(2 + k), 64'(32'h200 + k), 1'b0, '0, '0, 1'b0);
            stepCheck($sformatf("starveB%0d", k), 1'b1, 1'b1, 5'(2 + k), 64'(32'h200 + k),
                      (k == 3), 64'(15 + k));
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        stepCheck("starveC", 1'b1, 1'b1, 5'd21, 64'h21, 1'b0, 64'd19);

        // Reset with a full buffer: nothing stale may ever be written afterwards.
        applyStimulus(1'b0, 1'b1, 5'd3, 64'h3, 1'b1, 5'd22, 64'h22, 1'b0);
        stepCheck("rstD", 1'b1, 1'b1, 5'd3, 64'h3, 1'b0, 64'd20);
        applyStimulus(1'b0, 1'b1, 5'd3, 64'h33, 1'b1, 5'd23, 64'h23, 1'b0);
        stepCheck("rstE", 1'b1, 1'b1, 5'd3, 64'h33, 1'b0, 64'd21);
        applyStimulus(1'b1, 1'b1, 5'd4, 64'h44, 1'b1, 5'd24, 64'h24, 1'b0);
        stepCheck("rstF", 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        stepCheck("rstG", 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        stepCheck("rstH", 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);

        // Random traffic; the first two cycles hold reset so model and DUT start aligned.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus((i < 2) || ($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 99) < 55),
                          5'($urandom_range(0, 31)),
                          {$urandom(), $urandom()},
                          ($urandom_range(0, 99) < 60),
                          5'($urandom_range(0, 31)),
                          {$urandom(), $urandom()},
                          ($urandom_range(0, 99) < 4));
            #1;
            checkOutput($sformatf("rnd%0d ready", i), 64'(lsu_ready_o), 64'(modelReady()));
            modelStep();
            @(posedge clk);
            #1;
            checkOutput($sformatf("rnd%0d we", i), 64'(rf_we_o), 64'(mWe));
            checkOutput($sformatf("rnd%0d waddr", i), 64'(rf_waddr_o), 64'(mAddr));
            checkOutput($sformatf("rnd%0d wdata", i), rf_wdata_o, mData);
            checkOutput($sformatf("rnd%0d stall", i), 64'(stall_req_o), 64'(mStall));
            checkOutput($sformatf("rnd%0d count", i), wb_count_o, mCount);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
